// File: rtl/uart_tx_buffer_wb.sv
// uart_tx_buffer_wb: byte FIFO between the CPU bus and the Wishbone UART.
// The slave port accepts TXD pushes and STAT reads/clears with a one-cycle
// ack. A small Wishbone master drains the FIFO into the UART. It polls the
// UART status word for tx_busy (bit 9) and writes the UART data register
// whenever the transmitter is idle.
module uart_tx_buffer_wb #(
  parameter int DEPTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // CPU-facing slave port
  input  logic [2:2]  s_wb_adr_i,
  input  logic [31:0] s_wb_dat_i,
  output logic [31:0] s_wb_dat_o,
  input  logic        s_wb_we_i,
  input  logic [3:0]  s_wb_sel_i,
  input  logic        s_wb_stb_i,
  output logic        s_wb_ack_o,
  // UART-facing master port
  output logic [2:2]  m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  output logic        m_wb_we_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // UART status register bit that reports an ongoing transmission.
  localparam int TX_BUSY_BIT = 9;

  typedef enum logic [1:0] {
    IDLE,
    POLL,
    WRITE,
    GAP
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          s_ack_q, s_ack_d;

  state_e        state_q, state_d;
  logic          m_stb_q, m_stb_d;
  logic          m_we_q, m_we_d;
  logic [3:0]    m_sel_q, m_sel_d;
  logic [31:0]   m_dat_q, m_dat_d;
  logic [2:2]    m_adr_q, m_adr_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic       empty;
  logic       full;
  logic       s_access;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       ovf_clr;
  logic [7:0] count8;

  // Bits of the input words that this block intentionally ignores.
  logic unused_inputs;
  assign unused_inputs = ^{s_wb_dat_i[31:8], s_wb_sel_i[3:1],
                           m_wb_dat_i[31:TX_BUSY_BIT+1], m_wb_dat_i[TX_BUSY_BIT-1:0]};

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // Slave decode: an access takes effect on the edge where the ack rises.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would infer a latch.
    s_access = 1'b0;
    push_req = 1'b0;
    ovf_clr  = 1'b0;
    s_access = s_wb_stb_i & ~s_ack_q;
    push_req = s_access & s_wb_we_i & (s_wb_adr_i == 1'b0) & s_wb_sel_i[0];
    ovf_clr  = s_access & s_wb_we_i & (s_wb_adr_i == 1'b1) & s_wb_sel_i[0]
               & s_wb_dat_i[2];
  end

  // A push is rejected by the pre-edge full flag, even when a pop happens on
  // the same edge. A new overflow wins over a simultaneous clear.
  always_comb begin
    push    = push_req & ~full;
    s_ack_d = s_wb_stb_i & ~s_ack_q;
    ovf_d   = (push_req & full) | (ovf_q & ~ovf_clr);
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Slave read mux: TXD reads as zero, STAT packs the FIFO status.
  always_comb begin
    count8         = '0;
    count8[AW:0]   = count_q;
    s_wb_dat_o     = '0;
    if (s_wb_adr_i == 1'b1) begin
      s_wb_dat_o = {16'd0, count8, 5'd0, ovf_q, full, empty};
    end
  end

  // Master FSM next state: poll tx_busy, write the head byte when the
  // UART is idle, and always insert a one-cycle gap after a write or busy poll.
  always_comb begin
    state_d = state_q;
    m_stb_d = m_stb_q;
    m_we_d  = m_we_q;
    m_sel_d = m_sel_q;
    m_dat_d = m_dat_q;
    m_adr_d = m_adr_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = POLL;
          m_stb_d = 1'b1;
          m_we_d  = 1'b0;
          m_adr_d = 1'b0;
          m_sel_d = 4'b0010;
        end
      end
      POLL: begin
        if (m_wb_ack_i) begin
          if (m_wb_dat_i[TX_BUSY_BIT]) begin
            state_d = GAP;
            m_stb_d = 1'b0;
            m_we_d  = 1'b0;
            m_sel_d = 4'b0000;
          end else begin
            // Head byte is frozen here so later pushes cannot disturb it.
            state_d = WRITE;
            m_stb_d = 1'b1;
            m_we_d  = 1'b1;
            m_adr_d = 1'b0;
            m_sel_d = 4'b0001;
            m_dat_d = {24'd0, mem_q[rd_ptr_q]};
          end
        end
      end
      WRITE: begin
        if (m_wb_ack_i) begin
          pop     = 1'b1;
          state_d = GAP;
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          m_sel_d = 4'b0000;
        end
      end
      GAP: begin
        if (!empty) begin
          state_d = POLL;
          m_stb_d = 1'b1;
          m_we_d  = 1'b0;
          m_adr_d = 1'b0;
          m_sel_d = 4'b0010;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        m_stb_d = 1'b0;
        m_we_d  = 1'b0;
        m_sel_d = 4'b0000;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // FIFO storage write port.
  // NOTE: the data array has no reset; only pointers and count need one, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_wb_dat_i[7:0];
  end

  // FIFO control and slave-side status registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      s_ack_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      s_ack_q  <= s_ack_d;
    end
  end

  // Master FSM state and its registered bus outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_sel_q <= 4'b0000;
      m_dat_q <= '0;
      m_adr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_stb_q <= m_stb_d;
      m_we_q  <= m_we_d;
      m_sel_q <= m_sel_d;
      m_dat_q <= m_dat_d;
      m_adr_q <= m_adr_d;
    end
  end

  assign s_wb_ack_o = s_ack_q;
  assign m_wb_stb_o = m_stb_q;
  assign m_wb_we_o  = m_we_q;
  assign m_wb_sel_o = m_sel_q;
  assign m_wb_dat_o = m_dat_q;
  assign m_wb_adr_o = m_adr_q;

endmodule

// File: tb/tb_uart_tx_buffer_wb.sv
// Directed bench for uart_tx_buffer_wb with a behavioural Wishbone UART
// (ack toggles while strobed, tx_busy on read-data bit 9).
module tb_uart_tx_buffer_wb;

  logic        clk;
  logic        rst_n;
  logic [2:2]  s_adr;
  logic [31:0] s_dat_w;
  logic [31:0] s_dat_r;
  logic        s_we;
  logic [3:0]  s_sel;
  logic        s_stb;
  logic        s_ack;
  logic [2:2]  m_adr;
  logic [31:0] m_dat_w;
  logic [31:0] m_dat_r;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        m_stb;
  logic        u_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // UART model bookkeeping
  logic [7:0] rx_q[$];
  int         n_polls = 0;
  int         bad_poll_sel = 0;
  logic [3:0] last_psel = '0;
  logic [3:0] last_wsel = '0;

  uart_tx_buffer_wb #(.DEPTH(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .s_wb_adr_i (s_adr),
    .s_wb_dat_i (s_dat_w),
    .s_wb_dat_o (s_dat_r),
    .s_wb_we_i  (s_we),
    .s_wb_sel_i (s_sel),
    .s_wb_stb_i (s_stb),
    .s_wb_ack_o (s_ack),
    .m_wb_adr_o (m_adr),
    .m_wb_dat_o (m_dat_w),
    .m_wb_dat_i (m_dat_r),
    .m_wb_we_o  (m_we),
    .m_wb_sel_o (m_sel),
    .m_wb_stb_o (m_stb),
    .m_wb_ack_i (u_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign m_dat_r = {22'd0, busy, 9'd0};

  // Behavioural UART slave.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_ack <= 1'b0;
    end else begin
      u_ack <= m_stb & ~u_ack;
      if (m_stb && !u_ack) begin
        if (m_we) begin
          rx_q.push_back(m_dat_w[7:0]);
          last_wsel = m_sel;
        end else begin
          n_polls++;
          last_psel = m_sel;
          if (m_sel[0]) bad_poll_sel++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic adr, input logic [31:0] dat, input logic [3:0] sel);
    @(negedge clk);
    s_adr   = adr;
    s_dat_w = dat;
    s_sel   = sel;
    s_we    = 1'b1;
    s_stb   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_stb = 1'b0;
    s_we  = 1'b0;
  endtask

  task automatic wb_read(input logic adr, output logic [31:0] d);
    @(negedge clk);
    s_adr = adr;
    s_we  = 1'b0;
    s_sel = 4'hF;
    s_stb = 1'b1;
    @(posedge clk);
    #1;
    d = s_dat_r;
    @(negedge clk);
    s_stb = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(posedge clk);
    #1;
    check(tag, rx_q.size(), n);
  endtask

  logic [31:0] rd;
  int          base;
  int          polls0;
  logic        found;
  logic        push_done;

  initial begin
    rst_n   = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_stb   = 1'b0;
    busy    = 1'b0;

    // ---- reset state ----
    #23;
    check("rst_s_ack", s_ack, 0);
    check("rst_m_stb", m_stb, 0);
    check("rst_m_we",  m_we, 0);
    check("rst_m_sel", m_sel, 0);
    check("rst_m_dat", m_dat_w, 0);
    check("rst_m_adr", m_adr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(1'b1, rd);
    check("rst_stat", rd, 32'h0000_0001);
    wb_read(1'b0, rd);
    check("txd_read_zero", rd, 32'h0);

    // ---- single byte, cycle-accurate latency ----
    base   = rx_q.size();
    polls0 = n_polls;
    wb_write(1'b0, 32'hFFFF_FFA5, 4'b0001);
    check("lat_e_stb", m_stb, 0);
    @(posedge clk); #1;
    check("lat_e1_stb", m_stb, 1);
    check("lat_e1_we", m_we, 0);
    check("lat_e1_sel", m_sel, 4'b0010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_e3_we", m_we, 1);
    check("lat_e3_stb", m_stb, 1);
    check("lat_e3_dat", m_dat_w, 32'h0000_00A5);
    check("lat_e3_sel", m_sel, 4'b0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_e5_gap_stb", m_stb, 0);
    check("single_rx_cnt", rx_q.size(), base + 1);
    check("single_rx_byte", rx_q[base], 8'hA5);
    check("single_wsel", last_wsel, 4'b0001);
    check("single_psel", last_psel, 4'b0010);
    check("single_polls", n_polls - polls0, 1);
    wb_read(1'b1, rd);
    check("single_stat", rd, 32'h0000_0001);

    // ---- busy backpressure ----
    busy   = 1'b1;
    base   = rx_q.size();
    polls0 = n_polls;
    wb_write(1'b0, 32'h0000_003C, 4'b0001);
    repeat (20) @(posedge clk);
    #1;
    check("busy_no_write", rx_q.size(), base);
    check("busy_repolls", (n_polls - polls0) > 2, 1);
    @(negedge clk);
    busy = 1'b0;
    wait_rx(base + 1, 10, "busy_release_rx");
    if (rx_q.size() > base) check("busy_byte", rx_q[base], 8'h3C);

    // ---- full and overflow ----
    repeat (4) @(posedge clk);
    busy = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < 17; i++) wb_write(1'b0, 32'h50 + i, 4'b0001);
    wb_read(1'b1, rd);
    check("full_ovf_stat", rd, 32'h0000_1006);
    wb_write(1'b1, 32'h0000_0004, 4'b0001);
    wb_read(1'b1, rd);
    check("ovf_clear_stat", rd, 32'h0000_1002);
    busy = 1'b0;
    wait_rx(base + 16, 300, "full_drain_cnt");
    repeat (30) @(posedge clk);
    #1;
    check("full_no_17th", rx_q.size(), base + 16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < rx_q.size()) check("full_order", rx_q[base + i], 8'h50 + i);
    end
    wb_read(1'b1, rd);
    check("full_after_stat", rd, 32'h0000_0001);

    // ---- simultaneous push / pop at count 5 ----
    busy = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < 5; i++) wb_write(1'b0, 32'h70 + i, 4'b0001);
    wb_read(1'b1, rd);
    check("pp_pre_stat", rd, 32'h0000_0500);
    busy  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_stb && m_we && u_ack) found = 1'b1;
    end
    check("pp_pop_found", found, 1);
    // Strobe now so the push lands on the same edge as the pop.
    s_adr   = 1'b0;
    s_dat_w = 32'h75;
    s_sel   = 4'b0001;
    s_we    = 1'b1;
    s_stb   = 1'b1;
    busy    = 1'b1;
    @(negedge clk);
    s_stb = 1'b0;
    s_we  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pp_one_out", rx_q.size(), base + 1);
    wb_read(1'b1, rd);
    check("pp_count_kept", rd, 32'h0000_0500);
    busy = 1'b0;
    wait_rx(base + 6, 100, "pp_drain_cnt");
    for (int i = 0; i < 6; i++) begin
      if (base + i < rx_q.size()) check("pp_order", rx_q[base + i], 8'h70 + i);
    end

    // ---- ordering and pointer wrap with random busy ----
    repeat (4) @(posedge clk);
    base      = rx_q.size();
    push_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          for (int t = 0; t < 400 && (i - (rx_q.size() - base)) >= 15; t++) @(posedge clk);
          wb_write(1'b0, i, 4'b0001);
        end
        push_done = 1'b1;
      end
      begin
        for (int t = 0; t < 5000 && !(push_done && rx_q.size() >= base + 40); t++) begin
          @(negedge clk);
          busy = 1'($urandom_range(0, 1));
        end
        busy = 1'b0;
      end
    join
    wait_rx(base + 40, 300, "wrap_cnt");
    for (int i = 0; i < 40; i++) begin
      if (base + i < rx_q.size()) check("wrap_order", rx_q[base + i], i);
    end
    wb_read(1'b1, rd);
    check("wrap_stat", rd, 32'h0000_0001);
    check("poll_sel0_never", bad_poll_sel, 0);

    // ---- reset in the middle of a WRITE ----
    repeat (4) @(posedge clk);
    base = rx_q.size();
    busy = 1'b0;
    wb_write(1'b0, 32'h99, 4'b0001);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_stb && m_we) found = 1'b1;
    end
    check("mid_write_found", found, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stb", m_stb, 0);
    check("mid_rst_we", m_we, 0);
    check("mid_rst_s_ack", s_ack, 0);
    check("mid_rst_dat", m_dat_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_lost", rx_q.size(), base);
    wb_read(1'b1, rd);
    check("mid_rst_stat", rd, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer_wb.md
# uart_tx_buffer_wb

Transmit-side buffering stage that sits directly upstream of the Wishbone UART (simpleuart_wb) on the SoC bus. The CPU writes bytes into a DEPTH-entry FIFO through a Wishbone slave port and gets an ack in one cycle. A Wishbone master FSM drains the FIFO into the UART: it polls the UART status register and writes the UART data register whenever the transmitter is idle. The CPU never has to busy-wait on tx_busy.

## Interface
- DEPTH, 16: FIFO entries, power of two, 2..128.
- wb_clk_i  in  1  clock for both ports.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- s_wb_adr_i  in  [2:2]  slave register select: 0 = TXD, 1 = STAT.
- s_wb_dat_i  in  32  slave write data.
- s_wb_dat_o  out  32  slave read data; combinational from s_wb_adr_i.
- s_wb_we_i  in  1  slave write enable.
- s_wb_sel_i  in  4  slave byte selects.
- s_wb_stb_i  in  1  slave strobe.
- s_wb_ack_o  out  1  slave ack, registered, reset 0.
- m_wb_adr_o  out  [2:2]  master address to the UART, registered, reset 0.
- m_wb_dat_o  out  32  master write data, registered, reset 0.
- m_wb_dat_i  in  32  master read data from the UART.
- m_wb_we_o  out  1  master write enable, registered, reset 0.
- m_wb_sel_o  out  4  master byte selects, registered, reset 0.
- m_wb_stb_o  out  1  master strobe, registered, reset 0.
- m_wb_ack_i  in  1  master ack from the UART.

## Operation
**Slave port**
- Ack rule: s_wb_ack_o <= s_wb_stb_i & !s_wb_ack_o. Every access acks exactly once, one cycle after the strobe.
- A write takes effect on the edge where s_wb_ack_o rises, i.e. stb & !ack.
- TXD write with sel[0]=1: push s_wb_dat_i[7:0].
  - If the FIFO is full, the byte is dropped and ovf is set.
- TXD read returns 32'd0.
- STAT read returns {16'd0, count[7:0], 5'd0, ovf, full, empty}.
  - count is 0..DEPTH, zero-extended.
- STAT write with sel[0]=1 and dat[2]=1 clears ovf. All other STAT write bits are ignored.
- ovf is sticky. If a clear and a new overflow occur on the same edge, ovf stays 1.

**FIFO**
- Storage is a circular buffer with AW = log2(DEPTH) pointer bits; pointers wrap modulo DEPTH.
- Separate count register of AW+1 bits.
- Push and pop on the same edge leave count unchanged.
- full is evaluated from the pre-edge count. A push while full is rejected even if a pop happens on the same edge.

**Master FSM** (states IDLE, POLL, WRITE, GAP)
- IDLE: if the FIFO is not empty, go to POLL.
  - Assert stb=1, we=0, adr=0, sel=4'b0010.
  - sel[0] is never set on reads, so the UART receive byte is not consumed.
- POLL: on m_wb_ack_i, sample m_wb_dat_i[9] (UART tx_busy).
  - If 1: go to GAP, then POLL again.
  - If 0: go to WRITE with stb=1, we=1, adr=0, sel=4'b0001, dat={24'd0, fifo head}.
- WRITE: on m_wb_ack_i, pop the FIFO and go to GAP.
- GAP: stb=0, we=0, sel=0 for exactly one cycle. Then go to POLL if the FIFO is not empty, else IDLE.
- m_wb_stb_o is always dropped for at least one cycle after each ack. The UART ack toggles while stb is held.
- The head byte is latched into m_wb_dat_o on entering WRITE. Slave pushes during WRITE cannot change it.

## Timing
- Reset, asynchronous, effective immediately:
  - FSM goes to IDLE; pointers, count and ovf are cleared.
  - All registered outputs go to 0, so m_wb_stb_o drops even mid-transfer.
  - The byte being written is lost.
- Latency from a push into an empty FIFO, with the push acked at edge E:
  - m_wb_stb_o rises after edge E+1 (poll).
  - The poll ack arrives one cycle later.
  - The write strobe starts the cycle after the poll ack.
  - The pop happens on the edge where the write ack is sampled.
- Minimum time per byte with the UART idle is 5 cycles: POLL, POLL ack, WRITE, WRITE ack, GAP.
- The slave port never stalls. Slave accesses and master transfers proceed concurrently.

## Test plan
- **Reset mid-transfer:** assert wb_rst_ni=0 while m_wb_stb_o=1 in WRITE -> m_wb_stb_o=0 and s_wb_ack_o=0 immediately; STAT reads 32'h0000_0001 after release.
- **Single byte:** push 8'hA5 with a UART model reporting tx_busy=0 -> one poll read with sel=4'b0010, then one write with m_wb_dat_o=32'h0000_00A5 and sel=4'b0001 -> STAT back to 32'h0000_0001.
- **Busy backpressure:** hold tx_busy=1 for 20 cycles after pushing 8'h3C -> repeated POLL/GAP with no write; write of 8'h3C within 3 cycles of tx_busy=0 being sampled.
- **Full and overflow:** with DEPTH=16 and tx_busy=1, push 17 bytes -> STAT = 32'h0000_1006 (count 16, full, ovf); the 17th byte is never written out. Write STAT with dat=4 -> ovf=0.
- **Ordering and wrap:** stream 40 bytes 0x00..0x27 with tx_busy randomly toggling -> the UART receives exactly 0x00..0x27 in order (pointers wrap twice), with no poll read having sel[0]=1.
- **Simultaneous push/pop:** with count=5, push on the same edge as a write-ack pop -> count stays 5.
